// File: rtl/bp_fe_pkg.sv
// Shared FE-side types: processor configs, fe_cmd width lookup and the
// fe_cmd arbiter grant-source encoding.
package bp_fe_pkg;

  typedef enum logic [1:0] {
    e_bp_default_cfg,
    e_bp_unicore_cfg
  } bp_params_e;

  typedef enum logic [1:0] {
    e_arb_none,
    e_arb_redirect,
    e_arb_fill,
    e_arb_attaboy
  } bp_fe_arb_e;

  function automatic int fe_cmd_width(input bp_params_e cfg);
    return (cfg == e_bp_unicore_cfg) ? 96 : 109;
  endfunction

endpackage

// File: rtl/bp_fe_cmd_attaboy_fifo.sv
// Small attaboy queue: power-of-2 depth, same-edge flush, and simultaneous
// enqueue/dequeue (also when full, provided the caller dequeues).
module bp_fe_cmd_attaboy_fifo #(
  parameter int width_p = 8,
  parameter int els_p   = 4
) (
  input  logic               clk_i,
  input  logic               reset_n_i,
  input  logic               flush_i,
  input  logic               enq_i,
  input  logic [width_p-1:0] data_i,
  input  logic               deq_i,
  output logic [width_p-1:0] data_o,
  output logic               full_o,
  output logic               empty_o
);

  localparam int ptr_w_lp = $clog2(els_p);

  logic [width_p-1:0]  mem_q [els_p];
  logic [ptr_w_lp-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
  logic [ptr_w_lp:0]   cnt_q, cnt_d;

  always_comb begin
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    cnt_d  = cnt_q;
    if (flush_i) begin
      wptr_d = '0;
      rptr_d = '0;
      cnt_d  = '0;
    end else begin
      if (enq_i) wptr_d = wptr_q + ptr_w_lp'(1);
      if (deq_i) rptr_d = rptr_q + ptr_w_lp'(1);
      case ({enq_i, deq_i})
        2'b10:   cnt_d = cnt_q + (ptr_w_lp+1)'(1);
        2'b01:   cnt_d = cnt_q - (ptr_w_lp+1)'(1);
        default: cnt_d = cnt_q;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      cnt_q  <= cnt_d;
    end
  end

  // Storage needs no reset: the head is only consumed while cnt_q is non-zero.
  always_ff @(posedge clk_i) begin
    if (enq_i && !flush_i) mem_q[wptr_q] <= data_i;
  end

  assign data_o  = mem_q[rptr_q];
  assign full_o  = (cnt_q == (ptr_w_lp+1)'(els_p));
  assign empty_o = (cnt_q == '0);

endmodule

// File: rtl/bp_fe_cmd_arbiter.sv
// Merges redirect, fill and attaboy producers into the single registered
// fe_cmd valid/yumi channel feeding the FE controller.
module bp_fe_cmd_arbiter
  import bp_fe_pkg::*;
#(
  parameter bp_params_e bp_params_p = e_bp_default_cfg,
  parameter int attaboy_els_p    = 4,
  parameter int starve_limit_p   = 8,
  parameter int drop_cnt_width_p = 16,
  localparam int fe_cmd_width_lp = fe_cmd_width(bp_params_p)
) (
  input  logic                        clk_i,
  input  logic                        reset_n_i,
  input  logic [fe_cmd_width_lp-1:0]  redirect_cmd_i,
  input  logic                        redirect_v_i,
  output logic                        redirect_ready_and_o,
  input  logic [fe_cmd_width_lp-1:0]  fill_cmd_i,
  input  logic                        fill_v_i,
  output logic                        fill_ready_and_o,
  input  logic [fe_cmd_width_lp-1:0]  attaboy_cmd_i,
  input  logic                        attaboy_v_i,
  output logic [fe_cmd_width_lp-1:0]  fe_cmd_o,
  output logic                        fe_cmd_v_o,
  input  logic                        fe_cmd_yumi_i,
  output logic [drop_cnt_width_p-1:0] attaboy_drop_cnt_o,
  output logic                        busy_o
);

  localparam int starve_w_lp = $clog2(starve_limit_p + 1);
  localparam logic [starve_w_lp-1:0] starve_max_lp = starve_w_lp'(starve_limit_p);

  logic                        slot_v_q, slot_v_d;
  logic [fe_cmd_width_lp-1:0]  slot_q, slot_d;
  logic                        ready_q;
  logic [starve_w_lp-1:0]      starve_cnt_q, starve_cnt_d;
  logic [drop_cnt_width_p-1:0] drop_cnt_q, drop_cnt_d;

  logic                        fifo_full, fifo_empty, fifo_enq, fifo_deq;
  logic [fe_cmd_width_lp-1:0]  fifo_data;
  logic                        load_en, promote, flush, drop;
  bp_fe_arb_e                  grant;

  // ready_q holds the handshakes off until the first edge after reset release.
  assign load_en = ready_q & (~slot_v_q | fe_cmd_yumi_i);
  assign promote = ~fifo_empty & (starve_cnt_q == starve_max_lp);
  assign flush   = redirect_v_i & load_en;

  always_comb begin
    grant = e_arb_none;
    if (load_en) begin
      if (redirect_v_i)     grant = e_arb_redirect;
      else if (promote)     grant = e_arb_attaboy;
      else if (fill_v_i)    grant = e_arb_fill;
      else if (!fifo_empty) grant = e_arb_attaboy;
    end
  end

  assign fifo_deq = (grant == e_arb_attaboy);
  assign fifo_enq = attaboy_v_i & ~flush & (~fifo_full | fifo_deq);
  assign drop     = attaboy_v_i & ~flush & fifo_full & ~fifo_deq;

  always_comb begin
    slot_v_d     = slot_v_q;
    slot_d       = slot_q;
    starve_cnt_d = starve_cnt_q;
    drop_cnt_d   = drop_cnt_q;

    if (load_en) slot_v_d = (grant != e_arb_none);
    case (grant)
      e_arb_redirect: slot_d = redirect_cmd_i;
      e_arb_fill:     slot_d = fill_cmd_i;
      e_arb_attaboy:  slot_d = fifo_data;
      default:        slot_d = slot_q;
    endcase

    // Only cycles where the head genuinely lost a load opportunity count.
    if (flush || fifo_deq || fifo_empty) starve_cnt_d = '0;
    else if (load_en && starve_cnt_q != starve_max_lp)
      starve_cnt_d = starve_cnt_q + starve_w_lp'(1);

    if (drop && !(&drop_cnt_q)) drop_cnt_d = drop_cnt_q + drop_cnt_width_p'(1);
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      slot_v_q     <= 1'b0;
      slot_q       <= '0;
      ready_q      <= 1'b0;
      starve_cnt_q <= '0;
      drop_cnt_q   <= '0;
    end else begin
      slot_v_q     <= slot_v_d;
      slot_q       <= slot_d;
      ready_q      <= 1'b1;
      starve_cnt_q <= starve_cnt_d;
      drop_cnt_q   <= drop_cnt_d;
    end
  end

  bp_fe_cmd_attaboy_fifo #(
    .width_p (fe_cmd_width_lp),
    .els_p   (attaboy_els_p)
  ) attaboy_fifo (
    .clk_i     (clk_i),
    .reset_n_i (reset_n_i),
    .flush_i   (flush),
    .enq_i     (fifo_enq),
    .data_i    (attaboy_cmd_i),
    .deq_i     (fifo_deq),
    .data_o    (fifo_data),
    .full_o    (fifo_full),
    .empty_o   (fifo_empty)
  );

  assign fe_cmd_o             = slot_q;
  assign fe_cmd_v_o           = slot_v_q;
  assign redirect_ready_and_o = load_en;
  assign fill_ready_and_o     = load_en & ~redirect_v_i & ~promote;
  assign attaboy_drop_cnt_o   = drop_cnt_q;
  assign busy_o               = slot_v_q | ~fifo_empty;

endmodule

// File: tb/tb_bp_fe_cmd_arbiter.sv
// Scenario bench for bp_fe_cmd_arbiter: expected commands are queued as stimulus
// is driven and compared in order as the FE side consumes them.
module tb_bp_fe_cmd_arbiter;
  import bp_fe_pkg::*;

  localparam int W     = fe_cmd_width(e_bp_default_cfg);
  localparam int DW    = 16;
  localparam int LIMIT = 8;

  logic          clk = 1'b0;
  logic          reset_n;
  logic [W-1:0]  redirect_cmd, fill_cmd, attaboy_cmd, fe_cmd;
  logic          redirect_v, redirect_ready, fill_v, fill_ready, attaboy_v;
  logic          fe_cmd_v, fe_cmd_yumi, busy;
  logic [DW-1:0] drop_cnt;

  int            checks = 0;
  int            errors = 0;
  logic [W-1:0]  exp_q[$];

  always #5 clk = ~clk;

  bp_fe_cmd_arbiter #(
    .bp_params_p      (e_bp_default_cfg),
    .attaboy_els_p    (4),
    .starve_limit_p   (LIMIT),
    .drop_cnt_width_p (DW)
  ) dut (
    .clk_i                (clk),
    .reset_n_i            (reset_n),
    .redirect_cmd_i       (redirect_cmd),
    .redirect_v_i         (redirect_v),
    .redirect_ready_and_o (redirect_ready),
    .fill_cmd_i           (fill_cmd),
    .fill_v_i             (fill_v),
    .fill_ready_and_o     (fill_ready),
    .attaboy_cmd_i        (attaboy_cmd),
    .attaboy_v_i          (attaboy_v),
    .fe_cmd_o             (fe_cmd),
    .fe_cmd_v_o           (fe_cmd_v),
    .fe_cmd_yumi_i        (fe_cmd_yumi),
    .attaboy_drop_cnt_o   (drop_cnt),
    .busy_o               (busy)
  );

  always @(posedge clk) begin
    if (reset_n && fe_cmd_yumi) assert (fe_cmd_v) else $error("yumi asserted with no valid command");
  end

  function automatic logic [W-1:0] mk(input int tag);
    return W'(tag);
  endfunction

  // Consume the slot (when asked and valid) and compare it to the scoreboard head.
  task automatic pre(input bit consume);
    logic [W-1:0] exp;
    fe_cmd_yumi = consume & fe_cmd_v;
    if (fe_cmd_yumi) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL cmd_unexpected got=%h required=none", fe_cmd);
      end else begin
        exp = exp_q.pop_front();
        if (fe_cmd !== exp) begin
          errors++;
          $display("FAIL cmd_order got=%h required=%h", fe_cmd, exp);
        end else begin
          $display("consumed fe_cmd %h", fe_cmd);
        end
      end
    end
    #1;
  endtask

  task automatic post();
    @(posedge clk);
    #1;
    fe_cmd_yumi = 1'b0;
  endtask

  task automatic tick(input bit consume);
    pre(consume);
    post();
  endtask

  task automatic drain(input string name);
    for (int i = 0; i < 40 && exp_q.size() != 0; i++) tick(1'b1);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL %s_drain_timeout got=%0d pending required=0", name, exp_q.size());
    end
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    redirect_v = 0; fill_v = 0; attaboy_v = 0; fe_cmd_yumi = 0;
    redirect_cmd = '0; fill_cmd = '0; attaboy_cmd = '0;
    repeat (2) @(posedge clk);
    #1;
    checks++; if (fe_cmd_v !== 1'b0) begin errors++; $display("FAIL rst_v got=%b required=0", fe_cmd_v); end
    checks++; if (fe_cmd !== '0) begin errors++; $display("FAIL rst_cmd got=%h required=0", fe_cmd); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy got=%b required=0", busy); end
    checks++; if (drop_cnt !== '0) begin errors++; $display("FAIL rst_drop got=%0d required=0", drop_cnt); end
    checks++; if ({redirect_ready, fill_ready} !== 2'b00) begin errors++; $display("FAIL rst_ready got=%b required=00", {redirect_ready, fill_ready}); end
    reset_n = 1'b1;
    post();
    checks++; if ({redirect_ready, fill_ready} !== 2'b11) begin errors++; $display("FAIL post_rst_ready got=%b required=11", {redirect_ready, fill_ready}); end
    checks++; if ({fe_cmd_v, busy} !== 2'b00) begin errors++; $display("FAIL post_rst_idle got=%b required=00", {fe_cmd_v, busy}); end
    $display("test_reset done");
  endtask

  task automatic test_priority();
    redirect_cmd = mk('h11); redirect_v = 1;
    fill_cmd = mk('h21); fill_v = 1;
    exp_q.push_back(mk('h11));
    exp_q.push_back(mk('h21));
    pre(1'b1);
    checks++; if ({redirect_ready, fill_ready} !== 2'b10) begin errors++; $display("FAIL prio_ready_c0 got=%b required=10", {redirect_ready, fill_ready}); end
    post();
    redirect_v = 0;
    pre(1'b1);
    checks++; if (exp_q.size() != 1) begin errors++; $display("FAIL prio_redirect_c1 got=%0d pending required=1", exp_q.size()); end
    checks++; if (fill_ready !== 1'b1) begin errors++; $display("FAIL prio_fill_ready_c1 got=%b required=1", fill_ready); end
    post();
    fill_v = 0;
    pre(1'b1);
    checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL prio_fill_c2 got=%0d pending required=0", exp_q.size()); end
    post();
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL prio_idle_busy got=%b required=0", busy); end
  endtask

  task automatic test_attaboy_fifo();
    for (int i = 0; i < 5; i++) begin
      attaboy_cmd = mk('h30 + i); attaboy_v = 1;
      exp_q.push_back(mk('h30 + i));
      tick(1'b0);
    end
    attaboy_v = 0;
    checks++; if (fe_cmd_v !== 1'b1 || fe_cmd !== mk('h30)) begin errors++; $display("FAIL ab_slot got=%b/%h required=1/%h", fe_cmd_v, fe_cmd, mk('h30)); end
    checks++; if (drop_cnt !== 16'd0) begin errors++; $display("FAIL ab_no_drop got=%0d required=0", drop_cnt); end
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL ab_busy got=%b required=1", busy); end
    // Full FIFO with a same-cycle dequeue: the new attaboy must be kept.
    attaboy_cmd = mk('h35); attaboy_v = 1;
    exp_q.push_back(mk('h35));
    tick(1'b1);
    checks++; if (drop_cnt !== 16'd0) begin errors++; $display("FAIL ab_full_enq_deq got=%0d required=0", drop_cnt); end
    attaboy_cmd = mk('h36);
    tick(1'b0);
    attaboy_v = 0;
    checks++; if (drop_cnt !== 16'd1) begin errors++; $display("FAIL ab_drop got=%0d required=1", drop_cnt); end
    drain("ab");
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL ab_drained_busy got=%b required=0", busy); end
  endtask

  task automatic test_flush();
    for (int i = 0; i < 4; i++) begin
      attaboy_cmd = mk('h40 + i); attaboy_v = 1;
      tick(1'b0);
    end
    exp_q.push_back(mk('h40));
    redirect_cmd = mk('h12); redirect_v = 1;
    attaboy_cmd = mk('h44); attaboy_v = 1;
    exp_q.push_back(mk('h12));
    tick(1'b1);
    redirect_v = 0; attaboy_v = 0;
    checks++; if (fe_cmd_v !== 1'b1 || fe_cmd !== mk('h12)) begin errors++; $display("FAIL flush_slot got=%b/%h required=1/%h", fe_cmd_v, fe_cmd, mk('h12)); end
    checks++; if (drop_cnt !== 16'd1) begin errors++; $display("FAIL flush_drop got=%0d required=1", drop_cnt); end
    tick(1'b1);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL flush_empty got=%b required=0", busy); end
    checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL flush_pending got=%0d required=0", exp_q.size()); end
  endtask

  task automatic test_starve();
    int fill_idx;
    int first_stall;
    fill_cmd = mk('h50); fill_v = 1;
    exp_q.push_back(mk('h50));
    tick(1'b0);
    fill_v = 0;
    attaboy_cmd = mk('h60); attaboy_v = 1;
    tick(1'b0);
    attaboy_v = 0;
    for (int i = 1; i <= LIMIT; i++) exp_q.push_back(mk('h50 + i));
    exp_q.push_back(mk('h60));
    exp_q.push_back(mk('h59));
    exp_q.push_back(mk('h5a));
    fill_idx = 1;
    first_stall = -1;
    for (int c = 0; c < 30 && fill_idx <= 10; c++) begin
      fill_cmd = mk('h50 + fill_idx); fill_v = 1;
      pre(1'b1);
      if (fill_ready) fill_idx++;
      else if (first_stall < 0) first_stall = c;
      post();
    end
    fill_v = 0;
    checks++; if (first_stall != LIMIT) begin errors++; $display("FAIL starve_promote_cycle got=%0d required=%0d", first_stall, LIMIT); end
    drain("starve");
  endtask

  task automatic test_async_reset();
    redirect_cmd = mk('h13); redirect_v = 1;
    tick(1'b0);
    redirect_v = 0;
    checks++; if (fe_cmd_v !== 1'b1) begin errors++; $display("FAIL areset_loaded got=%b required=1", fe_cmd_v); end
    #2 reset_n = 1'b0;
    #1;
    checks++; if (fe_cmd_v !== 1'b0) begin errors++; $display("FAIL areset_v got=%b required=0", fe_cmd_v); end
    checks++; if (busy !== 1'b0 || drop_cnt !== '0) begin errors++; $display("FAIL areset_state got=%b/%0d required=0/0", busy, drop_cnt); end
    post();
    reset_n = 1'b1;
    tick(1'b1);
    tick(1'b1);
    checks++; if (fe_cmd_v !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL areset_stale got=%b/%b required=0/0", fe_cmd_v, busy); end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_priority();
    test_attaboy_fifo();
    test_flush();
    test_starve();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
